// File: rtl/add_pkg.sv
// Shared types and saturation-limit helpers for the add/accumulate datapath.
package add_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // Helpers return a wide vector; callers truncate to their own WIDTH (up to 64).
    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width, input logic is_signed);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width - int'(is_signed)) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width, input logic is_signed);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (is_signed && (i == width - 1)) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/add_sat_core.sv
// Combinational add/sub/accumulate core with carry, overflow and optional clamping.
module add_sat_core
    import add_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH, SIGNED != 0));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH, SIGNED != 0));

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             ovf_raw;

    always_comb begin
        x   = a;
        y   = b;
        cin = 1'b0;
        unique case (op)
            OP_SUB: begin
                y   = ~b;
                cin = 1'b1;
            end
            OP_ACC: begin
                x = acc;
                y = a;
            end
            default: ;
        endcase

        sum = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);

        // Signed overflow: both addends share a sign the result does not.
        if (SIGNED != 0) begin
            ovf_raw = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        end else if (op == OP_SUB) begin
            ovf_raw = ~sum[WIDTH];
        end else begin
            ovf_raw = sum[WIDTH];
        end

        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = ovf_raw;

        if ((SATURATE != 0) && ovf_raw) begin
            if (SIGNED != 0) begin
                result = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
            end else begin
                result = (op == OP_SUB) ? SAT_MIN : SAT_MAX;
            end
        end

        if (op == OP_CLR) begin
            result = '0;
            carry  = 1'b0;
            ovf    = 1'b0;
        end
    end

endmodule

// File: rtl/add_accum_unit.sv
// Registered add/sub/accumulate stage with an internal accumulator and valid/ready ports.
module add_accum_unit
    import add_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             ovf
);

    op_e              op_sel;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_ovf;
    logic             accept;

    assign op_sel = op_e'(op);

    add_sat_core #(
        .WIDTH    (WIDTH),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_core (
        .a      (a),
        .b      (b),
        .acc    (acc),
        .op     (op_sel),
        .result (core_result),
        .carry  (core_carry),
        .ovf    (core_ovf)
    );

    // Handshake: a beat transfers on any edge where valid && ready. in_ready
    // depends only on the output slot (empty, or being drained this cycle),
    // and the output beat holds c/carry/ovf stable until out_ready takes it.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            c         <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                c         <= core_result;
                carry     <= core_carry;
                ovf       <= core_ovf;
                if (op_sel == OP_ACC) begin
                    acc <= core_result;
                end else if (op_sel == OP_CLR) begin
                    acc <= '0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_accum_unit.sv
// Bench for add_accum_unit: three parameter variants share one stimulus stream and one scoreboard.
module tb_add_accum_unit;

    localparam int W = 8;
    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] SUB = 2'd1;
    localparam logic [1:0] ACC = 2'd2;
    localparam logic [1:0] CLR = 2'd3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         in_ready_o  [3];
    logic         out_valid_o [3];
    logic         carry_o     [3];
    logic         ovf_o       [3];
    logic [W-1:0] c_o         [3];

    int n_checks = 0;
    int n_errors = 0;

    // Each entry packs {c, carry, ovf} for instance g at bits [10*g +: 10].
    logic [29:0] exp_q[$];
    int          acc_m [3];
    logic [29:0] front;
    logic [29:0] entry;
    logic [9:0]  r;

    always #5 clk = ~clk;

    // Instance 0: unsigned wrap, 1: unsigned saturate, 2: signed saturate.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        add_accum_unit #(
            .WIDTH    (W),
            .SIGNED   ((g == 2) ? 1 : 0),
            .SATURATE ((g >= 1) ? 1 : 0)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_o[g]),
            .op        (op),
            .a         (a),
            .b         (b),
            .out_valid (out_valid_o[g]),
            .out_ready (out_ready),
            .c         (c_o[g]),
            .carry     (carry_o[g]),
            .ovf       (ovf_o[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference: true integer arithmetic, then wrap / range test / clamp.
    function automatic logic [9:0] ref_op(input bit sg, input bit sat, input logic [1:0] o,
                                          input int av, input int bv, input int accv);
        int p, q, wrapped, sres, res;
        bit cy, ov;
        if (o == CLR) return 10'd0;
        p = (o == ACC) ? accv : av;
        q = (o == ACC) ? av : bv;
        if (o == SUB) begin
            cy      = (p >= q);
            wrapped = (p - q + 256) % 256;
            sres    = sx(p) - sx(q);
        end else begin
            cy      = (p + q) > 255;
            wrapped = (p + q) % 256;
            sres    = sx(p) + sx(q);
        end
        if (sg) ov = (sres > 127) || (sres < -128);
        else    ov = (o == SUB) ? !cy : cy;
        res = wrapped;
        if (sat && ov) begin
            if (sg) res = (av >= 128) ? 128 : 127;
            else    res = (o == SUB) ? 0 : 255;
        end
        return {8'(res), cy, ov};
    endfunction

    // Monitor + scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int g = 0; g < 3; g++) acc_m[g] = 0;
        end else begin
            for (int g = 0; g < 3; g++) begin
                check($sformatf("out_valid[%0d]", g), 32'(out_valid_o[g]), 32'(exp_q.size() != 0));
                check($sformatf("in_ready[%0d]", g), 32'(in_ready_o[g]),
                      32'((exp_q.size() == 0) || out_ready));
            end
            if (exp_q.size() != 0) begin
                front = exp_q[0];
                for (int g = 0; g < 3; g++) begin
                    check($sformatf("result[%0d] {c,carry,ovf}", g),
                          32'({c_o[g], carry_o[g], ovf_o[g]}), 32'(front[10*g +: 10]));
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && ((exp_q.size() == 0) || out_ready || !out_valid_o[0])) begin
                entry = '0;
                for (int g = 0; g < 3; g++) begin
                    r = ref_op(g == 2, g >= 1, op, int'(a), int'(b), acc_m[g]);
                    entry[10*g +: 10] = r;
                    if (op == ACC) acc_m[g] = int'(r[9:2]);
                    if (op == CLR) acc_m[g] = 0;
                end
                exp_q.push_back(entry);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one op and returns #1 after the edge that accepted it.
    task automatic send(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv);
        int n;
        n = 0;
        in_valid = 1'b1;
        op = o;
        a  = av;
        b  = bv;
        while (!in_ready_o[0] && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) begin
            n_errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected 1", n);
        end
        tick(1);
    endtask

    task automatic expect_beat(input string name, input int g, input logic [7:0] ec,
                               input logic ecy, input logic eov);
        check({name, ".c"}, 32'(c_o[g]), 32'(ec));
        check({name, ".carry"}, 32'(carry_o[g]), 32'(ecy));
        check({name, ".ovf"}, 32'(ovf_o[g]), 32'(eov));
        check({name, ".out_valid"}, 32'(out_valid_o[g]), 32'd1);
    endtask

    function automatic logic [7:0] pick_operand();
        logic [7:0] pool [5];
        pool = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd255};
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 4)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        rst = 1'b1;
        tick(3);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset.out_valid[%0d]", g), 32'(out_valid_o[g]), 32'd0);
            check($sformatf("reset.c[%0d]", g), 32'(c_o[g]), 32'd0);
            check($sformatf("reset.flags[%0d]", g), 32'({carry_o[g], ovf_o[g]}), 32'd0);
        end
        rst = 1'b0;
        out_ready = 1'b1;

        send(ADD, 8'd200, 8'd100);
        expect_beat("u_wrap_add", 0, 8'd44, 1'b1, 1'b1);
        expect_beat("u_sat_add", 1, 8'd255, 1'b1, 1'b1);
        send(SUB, 8'd10, 8'd20);
        expect_beat("u_wrap_sub", 0, 8'd246, 1'b0, 1'b1);
        expect_beat("u_sat_sub", 1, 8'd0, 1'b0, 1'b1);
        send(ADD, 8'd3, 8'd4);
        expect_beat("u_sat_small", 1, 8'd7, 1'b0, 1'b0);
        send(ADD, 8'd100, 8'd100);
        expect_beat("s_sat_add", 2, 8'd127, 1'b0, 1'b1);
        send(SUB, 8'h9C, 8'd100);
        expect_beat("s_sat_sub", 2, 8'h80, 1'b1, 1'b1);
        send(ADD, 8'hFB, 8'd3);
        expect_beat("s_sat_neg", 2, 8'hFE, 1'b0, 1'b0);

        send(CLR, 8'd0, 8'd0);
        expect_beat("acc_clr", 0, 8'd0, 1'b0, 1'b0);
        send(ACC, 8'd5, 8'd0);
        expect_beat("acc_5", 0, 8'd5, 1'b0, 1'b0);
        send(ACC, 8'd7, 8'd0);
        expect_beat("acc_12", 0, 8'd12, 1'b0, 1'b0);
        send(ACC, 8'd250, 8'd0);
        expect_beat("acc_wrap", 0, 8'd6, 1'b1, 1'b1);
        in_valid = 1'b0;
        tick(1);

        send(CLR, 8'd0, 8'd0);
        send(ACC, 8'd5, 8'd0);
        out_ready = 1'b0;
        op = ACC;
        a  = 8'd1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp.in_ready", 32'(in_ready_o[0]), 32'd0);
            check("bp.c_hold", 32'(c_o[0]), 32'd5);
        end
        out_ready = 1'b1;
        tick(1);
        expect_beat("bp.release", 0, 8'd6, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick(1);

        send(CLR, 8'd0, 8'd0);
        send(ACC, 8'd5, 8'd0);
        send(ACC, 8'd7, 8'd0);
        expect_beat("rst.pre", 0, 8'd12, 1'b0, 1'b0);
        op  = ACC;
        a   = 8'd9;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst.out_valid", 32'(out_valid_o[0]), 32'd0);
        check("rst.c", 32'(c_o[0]), 32'd0);
        check("rst.flags", 32'({carry_o[0], ovf_o[0]}), 32'd0);
        send(ACC, 8'd3, 8'd0);
        expect_beat("rst.acc_restart", 0, 8'd3, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick(1);

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 2'($urandom_range(0, 3));
            a         = pick_operand();
            b         = pick_operand();
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(3);
        check("drain.queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
